// File: rtl/key_event_reader.sv
// rtl/key_event_reader.sv - debounced pushbutton reader with press/release/auto-repeat events
//
// Purpose: turns raw active-low DE1-SoC pushbuttons into clean single-cycle
// events. Each key runs through a two-flop synchronizer, a debounce filter,
// a press/release edge detector and a hold/auto-repeat state machine.
//
// Ports:
//   clk            system clock (clock_50 at top level)
//   reset          asynchronous, active-high reset
//   key_n          raw pushbuttons, active-low, asynchronous to clk
//   level          debounced key state, 1 = pressed
//   press          one-cycle pulse when level rises
//   release_pulse  one-cycle pulse when level falls
//   repeat_pulse   one-cycle auto-repeat pulse while a key is held
//   any_press      OR of press, same cycle
module key_event_reader #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              any_press
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX);

  typedef enum logic [1:0] {IDLE, HELD, RPT} hold_state_t;

  // Combinational "level is about to flip this edge" strobes, shared by the
  // edge detector, the hold FSM and any_press so all see the same event.
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] fall;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic          s;
    logic [DW-1:0] cnt;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          repeat_r;
    logic [HW-1:0] hcnt;
    hold_state_t   state;
    logic          flip;

    assign s       = ~sync2;
    assign flip    = (s != level_r) && (cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise[k] = flip & s;
    assign fall[k] = flip & ~s;

    // Synchronizer flops reset to 1 so a key held through reset is seen as a
    // fresh press once reset drops.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= key_n[k];
        sync2 <= sync1;
      end
    end

    // Debounce filter plus edge pulses. Any return of s to the current level
    // clears cnt, so only an uninterrupted run of DEBOUNCE_CYCLES flips level.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt       <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        press_r   <= rise[k];
        release_r <= fall[k];
        if (s == level_r) begin
          cnt <= '0;
        end else if (flip) begin
          level_r <= s;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    // Hold / auto-repeat FSM. A fall overrides everything, so release and
    // repeat can never coincide.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state    <= IDLE;
        hcnt     <= '0;
        repeat_r <= 1'b0;
      end else begin
        repeat_r <= 1'b0;
        if (fall[k]) begin
          state <= IDLE;
          hcnt  <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (rise[k]) begin
                state <= HELD;
                hcnt  <= '0;
              end
            end
            HELD: begin
              if (hcnt == HW'(HOLD_CYCLES - 1)) begin
                repeat_r <= 1'b1;
                state    <= RPT;
                hcnt     <= '0;
              end else begin
                hcnt <= hcnt + 1'b1;
              end
            end
            RPT: begin
              if (hcnt == HW'(REPEAT_CYCLES - 1)) begin
                repeat_r <= 1'b1;
                hcnt     <= '0;
              end else begin
                hcnt <= hcnt + 1'b1;
              end
            end
            default: begin
              state <= IDLE;
              hcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign level[k]         = level_r;
    assign press[k]         = press_r;
    assign release_pulse[k] = release_r;
    assign repeat_pulse[k]  = repeat_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |rise;
    end
  end

endmodule

// File: tb/tb_key_event_reader.sv
// tb/tb_key_event_reader.sv - self-checking bench for key_event_reader
module tb_key_event_reader;

  localparam int NK = 4;
  localparam int D  = 4;
  localparam int H  = 10;
  localparam int R  = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] level;
  logic [NK-1:0] press;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] repeat_pulse;
  logic          any_press;

  always #5 clk = ~clk;

  key_event_reader #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .level(level), .press(press),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse), .any_press(any_press)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: synchronizer as a two-deep delay line, debounce as the
  // edge number at which s started disagreeing with level, auto-repeat as
  // arithmetic on the distance from the press edge.
  logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_rpt;
  logic          m_any;
  int            diff_start [NK];
  int            press_at   [NK];
  int            edge_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] dut_vec();
    return {15'd0, level, press, release_pulse, repeat_pulse, any_press};
  endfunction

  function automatic logic [31:0] model_vec();
    return {15'd0, m_level, m_press, m_rel, m_rpt, m_any};
  endfunction

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_level = '0;
    m_press = '0; m_rel = '0; m_rpt = '0; m_any = 1'b0;
    for (int k = 0; k < NK; k++) begin
      diff_start[k] = -1;
      press_at[k]   = -1;
    end
  endtask

  task automatic model_edge();
    logic s;
    int   d;
    edge_n++;
    m_press = '0; m_rel = '0; m_rpt = '0;
    for (int k = 0; k < NK; k++) begin
      s = ~m_s2[k];
      if (s == m_level[k]) begin
        diff_start[k] = -1;
      end else begin
        if (diff_start[k] < 0) diff_start[k] = edge_n;
        if (edge_n - diff_start[k] == D - 1) begin
          m_level[k]    = s;
          diff_start[k] = -1;
          if (s) begin
            m_press[k]  = 1'b1;
            press_at[k] = edge_n;
          end else begin
            m_rel[k]    = 1'b1;
            press_at[k] = -1;
          end
        end
      end
      if (press_at[k] >= 0 && !m_press[k]) begin
        d = edge_n - press_at[k];
        if (d >= H && (d - H) % R == 0) m_rpt[k] = 1'b1;
      end
    end
    m_s2  = m_s1;
    m_s1  = key_n;
    m_any = |m_press;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    check("outs", dut_vec(), model_vec());
  endtask

  int press_e, rel_e, rpt_n;
  int rpt_e [4];
  logic [NK-1:0] pv;
  logic          pv_any;
  int dur [NK];

  initial begin
    // Test 1: asynchronous reset with all keys pressed
    #1 key_n = '0; reset = 1'b1;
    #1 model_reset();
    check("rst_async", dut_vec(), 32'd0);
    repeat (3) tick();
    key_n = '1; reset = 1'b0;
    repeat (6) tick();

    // Test 2: 3-cycle glitch is rejected
    key_n[0] = 1'b0;
    repeat (3) tick();
    key_n[0] = 1'b1;
    repeat (8) tick();
    check("glitch_level", {31'd0, level[0]}, 32'd0);

    // Tests 3, 4: clean press then auto-repeat
    key_n[0] = 1'b0;
    press_e = -1; rpt_n = 0;
    for (int i = 0; i < 4; i++) rpt_e[i] = -1;
    for (int e = 0; e <= 24; e++) begin
      tick();
      if (press[0] && press_e < 0) press_e = e;
      if (repeat_pulse[0]) begin
        if (rpt_n < 4) rpt_e[rpt_n] = e;
        rpt_n++;
      end
    end
    check("press_edge", press_e, 5);
    check("rpt_count", rpt_n, 4);
    for (int i = 0; i < 4; i++) check("rpt_edge", rpt_e[i], 15 + R * i);

    // Test 5a: release during RPT
    key_n[0] = 1'b1;
    rel_e = -1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (release_pulse[0] && rel_e < 0) rel_e = e;
    end
    check("release_edge", rel_e, 5);

    // Test 5b: simultaneous presses on keys 1 and 2
    key_n[2:1] = 2'b00;
    pv = '0; pv_any = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (press != '0 && pv == '0) begin
        pv     = press;
        pv_any = any_press;
      end
    end
    check("press_vec", {28'd0, pv}, 32'h6);
    check("press_any", {31'd0, pv_any}, 32'd1);
    key_n[2:1] = 2'b11;
    repeat (8) tick();

    // Test 6: reset at edge 17 of a hold
    key_n[0] = 1'b0;
    repeat (18) tick();
    #1 reset = 1'b1;
    #1 model_reset();
    check("rst_mid", dut_vec(), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    press_e = -1; rel_e = -1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (press[0] && press_e < 0) press_e = e;
      if (release_pulse[0]) rel_e = e;
    end
    check("rst_press_edge", press_e, 5);
    check("rst_no_release", rel_e, -1);

    // Randomized key activity against the model
    for (int k = 0; k < NK; k++) dur[k] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (dur[k] == 0) begin
          key_n[k] = 1'($urandom_range(0, 1));
          dur[k]   = $urandom_range(1, 16);
        end
        dur[k]--;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
